test_dec3x8: RTL and testbench

TEST_DEC3X8 -- requirements
Module: test_dec3x8

---
 rtl/test_dec3x8_pkg.sv | 17 +
 rtl/test_dec3x8_dec2x4.sv | 25 ++
 rtl/test_dec3x8.sv | 56 +++++
 tb/tb_test_dec3x8.sv | 135 +++++++++++++
 4 files changed

// File: rtl/test_dec3x8_pkg.sv
// -----------------------------------------------------------------------------
// test_dec3x8_pkg
// Shared constants for the 3-to-8 decoder slice.
//   ADDR_W          : select address width (3)
//   OUT_W           : decoded output width (8)
//   SUB_OUT_W       : output width of one 2-to-4 bank (4)
//   DEC_RST_DEFAULT : default value loaded into the registered output on reset
// -----------------------------------------------------------------------------
package test_dec3x8_pkg;

    localparam int ADDR_W    = 3;
    localparam int OUT_W     = 8;
    localparam int SUB_OUT_W = 4;

    localparam logic [OUT_W-1:0] DEC_RST_DEFAULT = 8'h00;

endpackage : test_dec3x8_pkg

// File: rtl/test_dec3x8_dec2x4.sv
// -----------------------------------------------------------------------------
// dec2x4
// Purely combinational 2-to-4 one-hot decoder with active-high enable.
// Ports:
//   E : enable; when low every output bit is 0
//   A : 2-bit select
//   D : one-hot decode, D[i] = E & (A == i)
// -----------------------------------------------------------------------------
module dec2x4
    import test_dec3x8_pkg::*;
(
    input  logic                 E,
    input  logic [1:0]           A,
    output logic [SUB_OUT_W-1:0] D
);

    // One comparator per output bit. An X/Z on E or A yields X on the
    // affected bits rather than a spurious one-hot pattern.
    generate
        for (genvar gi = 0; gi < SUB_OUT_W; gi++) begin : g_bit
            assign D[gi] = E & (A == 2'(gi));
        end
    endgenerate

endmodule : dec2x4

// File: rtl/test_dec3x8.sv
// -----------------------------------------------------------------------------
// test_dec3x8
// 3-to-8 one-hot decoder built from two 2-to-4 banks, plus a registered copy.
// Parameters:
//   RST_VAL : value loaded into D_q on a reset edge
// Ports:
//   clk : rising-edge clock for the registered path
//   rst : synchronous active-high reset, affects D_q only
//   E   : active-high decoder enable
//   A   : 3-bit select, A[2] MSB
//   D   : combinational one-hot decode (zero when E=0)
//   D_q : D registered one clock later
// -----------------------------------------------------------------------------
module test_dec3x8
    import test_dec3x8_pkg::*;
#(
    parameter logic [OUT_W-1:0] RST_VAL = DEC_RST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              E,
    input  logic [ADDR_W-1:0] A,
    output logic [OUT_W-1:0]  D,
    output logic [OUT_W-1:0]  D_q
);

    logic [OUT_W-1:0] d_q_reg;

    // Bank 0 (low, D[3:0]) is enabled when A[2]=0, bank 1 (high, D[7:4])
    // when A[2]=1. Both banks see the same low address bits.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            logic bank_en;

            assign bank_en = E & (A[ADDR_W-1] == 1'(gi));

            dec2x4 u_dec2x4 (
                .E (bank_en),
                .A (A[1:0]),
                .D (D[gi*SUB_OUT_W +: SUB_OUT_W])
            );
        end
    endgenerate

    // Reset wins over the capture of D; D itself never sees rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q_reg <= RST_VAL;
        end else begin
            d_q_reg <= D;
        end
    end

    assign D_q = d_q_reg;

endmodule : test_dec3x8

// File: tb/tb_test_dec3x8.sv
// -----------------------------------------------------------------------------
// tb_test_dec3x8
// Scoreboard bench for test_dec3x8: expected D and D_q values are queued when
// inputs are driven and popped when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_test_dec3x8;

    logic       clk;
    logic       rst;
    logic       E;
    logic [2:0] A;
    logic [7:0] D;
    logic [7:0] D_q;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [7:0] d_exp_q[$];
    logic [7:0] dq_exp_q[$];
    logic [7:0] dq_model;

    test_dec3x8 dut (
        .clk (clk),
        .rst (rst),
        .E   (E),
        .A   (A),
        .D   (D),
        .D_q (D_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: D = E ? 1 << A : 0.
    function automatic logic [7:0] dec_model(input logic e, input logic [2:0] a);
        logic [7:0] one;
        one = 8'h01;
        return e ? (one << a) : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, queue what D and D_q must become,
    // then check D 1 ns later and that D_q has not moved yet.
    task automatic drive(input logic e, input logic [2:0] a, input logic r, input string tag);
        logic [7:0] exp_d;
        @(negedge clk);
        E   = e;
        A   = a;
        rst = r;
        d_exp_q.push_back(dec_model(e, a));
        dq_exp_q.push_back(r ? 8'h00 : dec_model(e, a));
        #1;
        exp_d = d_exp_q.pop_front();
        chk({tag, "_d"}, D, exp_d);
        chk({tag, "_onehot"}, 8'($countones(D)), e ? 8'd1 : 8'd0);
        chk({tag, "_dq_hold"}, D_q, dq_model);
        $display("txn %s e=%0d a=%0d rst=%0d d=%h d_q=%h", tag, e, a, r, D, D_q);
    endtask

    // Rising edge, then compare D_q with the oldest queued expectation.
    task automatic tick(input string tag);
        logic [7:0] exp_q;
        @(posedge clk);
        #1;
        if (dq_exp_q.size() == 0) begin
            chk({tag, "_dq_noexp"}, D_q, ~D_q);
        end else begin
            exp_q = dq_exp_q.pop_front();
            chk({tag, "_dq"}, D_q, exp_q);
            dq_model = exp_q;
        end
        $display("txn %s edge d_q=%h", tag, D_q);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=%h want=%h", D_q, dq_model);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        E   = 1'b0;
        A   = 3'd0;
        dq_model = 8'h00;

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_dq", D_q, 8'h00);
        $display("txn reset d_q=%h", D_q);

        // All 16 (E,A) combinations: zero sweep with E=0, then one-hot sweep
        for (int e = 0; e < 2; e++) begin
            for (int a = 0; a < 8; a++) begin
                drive(1'(e), 3'(a), 1'b0, $sformatf("sweep_e%0d_a%0d", e, a));
                tick($sformatf("sweep_e%0d_a%0d", e, a));
            end
        end

        // Single capture of A=101
        drive(1'b1, 3'b101, 1'b0, "cap_a5");
        tick("cap_a5");

        // Reset mid-stream: D keeps decoding, D_q clears, then recaptures
        drive(1'b1, 3'b011, 1'b1, "rst_a3");
        tick("rst_a3");
        chk("rst_a3_d_during", D, 8'h08);
        drive(1'b1, 3'b011, 1'b0, "post_rst_a3");
        tick("post_rst_a3");

        // Enable drop without a clock edge
        drive(1'b1, 3'b110, 1'b0, "tog_a6");
        E = 1'b0;
        void'(dq_exp_q.pop_back());
        dq_exp_q.push_back(dec_model(1'b0, 3'b110));
        d_exp_q.push_back(dec_model(1'b0, 3'b110));
        #1;
        chk("tog_a6_d_off", D, d_exp_q.pop_front());
        chk("tog_a6_dq_hold", D_q, dq_model);
        $display("txn tog_a6 e=0 d=%h d_q=%h", D, D_q);
        tick("tog_a6");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_test_dec3x8
